fetch_unit: RTL and testbench

Instruction-fetch stage placed directly upstream of the synchronous-read instruction memory and directly upstream of decode.

- Owns the program counter and drives the memory read address.
- Tracks the one-cycle read latency and registers each returned word with its PC into the IF/ID output.
- Supports decode back-pressure through a valid/ready handshake and a one-entry skid buffer.
- Accepts a branch redirect (brn) that flushes every in-flight and buffered fetch.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 88 ++++++++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, the NOP encoding and the opcode map.
// Pure declarations, so there is no latency and no backpressure.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [31:0] NOP = 32'h0;

  localparam logic [3:0] ADD  = 4'b0100;
  localparam logic [3:0] INC  = 4'b0101;
  localparam logic [3:0] SUB  = 4'b0111;
  localparam logic [3:0] BRN  = 4'b1011;
  localparam logic [3:0] LD   = 4'b1110;
  localparam logic [3:0] SVPC = 4'b1111;

endpackage

// File: rtl/fetch_skid_buf.sv
// IF/ID output register with a one-entry skid slot; the output updates 1 edge after input.
// When out_rdy is low, one extra word parks in the skid slot; skid_free gates issue upstream.
module fetch_skid_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              skid_free,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_rdy
);
  import cpu_pkg::*;

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              accept;

  // out_rdy only matters while a word is presented
  assign accept = !out_v_q || out_rdy;

  always_comb begin
    out_v_d      = out_v_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (accept) begin
      if (skid_v_q) begin
        out_v_d      = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_v_d     = in_vld;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end else begin
        out_v_d = in_vld;
        if (in_vld) begin
          out_instr_d = in_instr;
          out_pc_d    = in_pc;
        end
      end
    end else if (in_vld) begin
      skid_v_d     = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end
  end

  assign skid_free = !skid_v_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_v_q      <= 1'b0;
      out_instr_q  <= NOP;
      out_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
    end else begin
      out_v_q      <= out_v_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_vld   = out_v_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-cycle memory latency tracking, IF/ID register; fill latency 2 edges.
// Decode stalls via instr_ready; issue stops once the skid slot is occupied, and a redirect flushes all.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_v_q, infl_v_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              skid_free;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .in_vld    (infl_v_q),
    .in_instr  (imem_data),
    .in_pc     (infl_pc_q),
    .skid_free (skid_free),
    .out_vld   (instr_valid),
    .out_instr (instr_out),
    .out_pc    (instr_pc),
    .out_rdy   (instr_ready)
  );

  // The memory samples pc_q on every edge, so a held PC is re-read on the issue after a stall.
  // A non-issuing edge always leaves the inflight slot empty: its word went to skid or output.
  always_comb begin
    pc_d      = pc_q;
    infl_v_d  = 1'b0;
    infl_pc_d = infl_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (skid_free) begin
      infl_v_d  = 1'b1;
      infl_pc_d = pc_q;
      pc_d      = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      infl_v_q  <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_v_q  <= infl_v_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {pc, word}, a negedge monitor pops on each handshake.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [31:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  fetch_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [256];
  always @(posedge clock) imem_data <= mem[imem_addr];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_range(input logic [7:0] first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = first + 8'(i);
      e.instr = mem[e.pc];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_pc(input logic [7:0] p);
    int n;
    n = 0;
    while (!(instr_valid && instr_pc == p) && n < 400) begin
      tick();
      n++;
    end
    check("wait_pc_reached", {31'b0, instr_valid && instr_pc == p}, 32'd1);
  endtask

  // Monitor: a transfer is valid & ready on an edge without a redirect
  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h, required no word", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", {24'b0, instr_pc}, {24'b0, mon_e.pc});
        check("sb_instr", instr_out, mon_e.instr);
      end
    end
    if (reset_n && !redirect_valid && dut.infl_v_q && dut.u_skid.skid_v_q &&
        dut.u_skid.out_v_q && !instr_ready) begin
      failures++;
      $display("FAIL skid_overflow: got inflight word with skid full, required no overflow");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
    mem[2]  = 32'h71041000;
    mem[7]  = 32'h5104FC00;
    mem[12] = 32'h41420C00;
    mem[37] = 32'hB00A0000;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 8'd0;

    #12;
    check("rst_addr",  {24'b0, imem_addr}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc",    {24'b0, instr_pc}, 32'd0);

    push_range(8'd0, 37);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    check("fill_valid_e1", {31'b0, instr_valid}, 32'd0);
    check("fill_addr_e1",  {24'b0, imem_addr}, 32'd1);
    tick();
    check("fill_valid_e2", {31'b0, instr_valid}, 32'd1);
    check("fill_pc_e2",    {24'b0, instr_pc}, 32'd0);

    wait_pc(8'd2);
    check("word_addr2", instr_out, 32'h71041000);
    wait_pc(8'd7);
    check("word_addr7", instr_out, 32'h5104FC00);

    wait_pc(8'd12);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr_out, 32'h41420C00);
      check("stall_pc",    {24'b0, instr_pc}, 32'd12);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_addr",  {24'b0, imem_addr}, 32'd14);
    end
    instr_ready = 1'b1;

    wait_pc(8'd37);
    check("word_addr37", instr_out, 32'hB00A0000);
    push_range(8'd42, 3);
    redirect_valid  = 1'b1;
    redirect_target = 8'd42;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble1", {31'b0, instr_valid}, 32'd0);
    tick();
    check("redir_bubble2", {31'b0, instr_valid}, 32'd0);
    tick();
    check("redir_valid", {31'b0, instr_valid}, 32'd1);
    check("redir_pc",    {24'b0, instr_pc}, 32'd42);

    wait_pc(8'd45);
    instr_ready = 1'b0;
    tick();
    tick();
    check("skidfull_addr", {24'b0, imem_addr}, 32'd47);
    push_range(8'd100, 3);
    redirect_valid  = 1'b1;
    redirect_target = 8'd100;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("flush_bubble1", {31'b0, instr_valid}, 32'd0);
    tick();
    check("flush_bubble2", {31'b0, instr_valid}, 32'd0);
    tick();
    check("flush_valid", {31'b0, instr_valid}, 32'd1);
    check("flush_pc",    {24'b0, instr_pc}, 32'd100);

    wait_pc(8'd103);
    push_range(8'hFE, 5);
    redirect_valid  = 1'b1;
    redirect_target = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("wrap_pc_fe", {24'b0, instr_pc}, 32'h0000_00FE);

    wait_pc(8'd3);
    push_range(8'd0, 5);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_addr",  {24'b0, imem_addr}, 32'd0);
    check("arst_pc",    {24'b0, instr_pc}, 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    check("refill_valid_e1", {31'b0, instr_valid}, 32'd0);
    tick();
    check("refill_pc_e2", {24'b0, instr_pc}, 32'd0);

    wait_pc(8'd5);
    instr_ready = 1'b0;
    tick();
    tick();
    check("final_hold_pc", {24'b0, instr_pc}, 32'd5);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
